// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI slave.
package spi_pkg;
   localparam int SPI_BITS = 8;
   localparam int CNT_W = $clog2(SPI_BITS);
   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
   typedef enum logic [1:0] {MODE0 = 2'd0, MODE1 = 2'd1, MODE2 = 2'd2, MODE3 = 2'd3} spi_mode_t;
   function automatic logic mode_cpol(input logic [1:0] m);
      return m[1];
   endfunction
   function automatic logic mode_cpha(input logic [1:0] m);
      return m[0];
   endfunction
endpackage

// File: rtl/spi_sync.sv
// spi_sync: 2-flop synchronizer whose flops preset to init during reset.
module spi_sync (
   input  logic clk,
   input  logic rst,
   input  logic init,
   input  logic d,
   output logic q
);
   logic [1:0] sync_q, sync_d;
   always_comb sync_d = {sync_q[0], d};
   always_ff @(posedge clk)
      if (!rst) sync_q <= {2{init}};
      else sync_q <= sync_d;
   assign q = sync_q[1];
endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI slave, modes 0-3, MSB first, single-byte tx buffer.
// Define SPI_SLAVE_UNDERRUN_EN to enable the sticky transmit-underrun flag.
import spi_pkg::*;
module spi_slave (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          MODE,
   input  logic                Sclk,
   input  logic                SS,
   input  logic                MOSI,
   output logic                MISO,
   input  logic [SPI_BITS-1:0] tx_data,
   input  logic                tx_load,
   output logic                tx_ready,
   output logic [SPI_BITS-1:0] rx_data,
   output logic                rx_valid,
   output logic                busy,
   output logic                underrun
);
   logic sclk_s, ss_s, mosi_s;
   spi_sync u_sclk (.clk(clk), .rst(rst), .init(mode_cpol(MODE)), .d(Sclk), .q(sclk_s));
   spi_sync u_ss   (.clk(clk), .rst(rst), .init(1'b1),            .d(SS),   .q(ss_s));
   spi_sync u_mosi (.clk(clk), .rst(rst), .init(1'b0),            .d(MOSI), .q(mosi_s));
   state_t              state_q, state_d;
   logic [1:0]          mode_q, mode_d;
   logic                sclk_prev_q, sclk_prev_d, ss_prev_q, ss_prev_d;
   logic [SPI_BITS-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
   logic [SPI_BITS-1:0] rx_data_q, rx_data_d, tx_buf_q, tx_buf_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                rx_valid_q, rx_valid_d, tx_ready_q, tx_ready_d;
   logic                ss_fall, sclk_edge, leading, trailing, sample, shift, load_acc, enter;
   always_comb begin
      ss_fall     = ss_prev_q & ~ss_s;
      sclk_edge   = sclk_s ^ sclk_prev_q;
      leading     = sclk_edge & (sclk_s != mode_cpol(mode_q));
      trailing    = sclk_edge & (sclk_s == mode_cpol(mode_q));
      sample      = (state_q == XFER) & (mode_cpha(mode_q) ? trailing : leading);
      // the first shift-type edge of a byte must not disturb the freshly loaded MSB
      shift       = (state_q == XFER) & (mode_cpha(mode_q) ? leading : trailing) & (cnt_q != '0);
      load_acc    = tx_load & tx_ready_q;
      enter       = ((state_q == IDLE) & ss_fall) | ((state_q == DONE) & ~ss_s);
      state_d     = (state_q == IDLE) ? (ss_fall ? XFER : IDLE) :
                    (state_q == DONE) ? (ss_s ? IDLE : XFER) :
                    ss_s ? IDLE :
                    (sample && cnt_q == CNT_W'(SPI_BITS - 1)) ? DONE : XFER;
      mode_d      = ((state_q == IDLE) & ss_fall) ? MODE : mode_q;
      sclk_prev_d = sclk_s;
      ss_prev_d   = ss_s;
      tx_sr_d     = enter ? (tx_ready_q ? '0 : tx_buf_q) :
                    shift ? {tx_sr_q[SPI_BITS-2:0], 1'b0} : tx_sr_q;
      rx_sr_d     = sample ? {rx_sr_q[SPI_BITS-2:0], mosi_s} : rx_sr_q;
      cnt_d       = enter ? '0 : sample ? cnt_q + CNT_W'(1) : cnt_q;
      rx_data_d   = (state_q == DONE) ? rx_sr_q : rx_data_q;
      rx_valid_d  = (state_q == DONE);
      tx_buf_d    = load_acc ? tx_data : tx_buf_q;
      tx_ready_d  = load_acc ? 1'b0 : enter ? 1'b1 : tx_ready_q;
   end
   always_ff @(posedge clk)
      if (!rst) begin
         state_q     <= IDLE;
         mode_q      <= MODE;
         sclk_prev_q <= mode_cpol(MODE);
         ss_prev_q   <= 1'b1;
         tx_sr_q     <= '0;
         rx_sr_q     <= '0;
         cnt_q       <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         tx_buf_q    <= '0;
         tx_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         sclk_prev_q <= sclk_prev_d;
         ss_prev_q   <= ss_prev_d;
         tx_sr_q     <= tx_sr_d;
         rx_sr_q     <= rx_sr_d;
         cnt_q       <= cnt_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         tx_buf_q    <= tx_buf_d;
         tx_ready_q  <= tx_ready_d;
      end
`ifdef SPI_SLAVE_UNDERRUN_EN
   logic underrun_q, underrun_d;
   always_comb underrun_d = (enter & tx_ready_q) ? 1'b1 : load_acc ? 1'b0 : underrun_q;
   always_ff @(posedge clk)
      if (!rst) underrun_q <= 1'b0;
      else underrun_q <= underrun_d;
   assign underrun = underrun_q;
`else
   assign underrun = 1'b0;
`endif
   assign MISO     = SS ? 1'bz : tx_sr_q[SPI_BITS-1];
   assign busy     = (state_q != IDLE);
   assign tx_ready = tx_ready_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL provide port clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-002 The block SHALL provide port rst, input, 1 bit: reset, synchronous, active-low.
REQ-003 The block SHALL provide port MODE, input, 2 bits: SPI mode; 0=CPOL0/CPHA0, 1=CPOL0/CPHA1, 2=CPOL1/CPHA0, 3=CPOL1/CPHA1.
REQ-004 The block SHALL provide port Sclk, input, 1 bit: serial clock from the master, asynchronous to clk.
REQ-005 The block SHALL provide port SS, input, 1 bit: slave select, active-low, asynchronous.
REQ-006 The block SHALL provide port MOSI, input, 1 bit: serial data from the master.
REQ-007 The block SHALL provide port MISO, output, 1 bit: serial data to the master; high-Z while SS=1.
REQ-008 The block SHALL provide port tx_data, input, 8 bits: next byte to transmit.
REQ-009 The block SHALL provide port tx_load, input, 1 bit: write strobe for tx_data.
REQ-010 The block SHALL provide port tx_ready, output, 1 bit: transmit buffer empty.
REQ-011 The block SHALL provide port rx_data, output, 8 bits: last complete received byte.
REQ-012 The block SHALL provide port rx_valid, output, 1 bit: one-cycle pulse; rx_data updated.
REQ-013 The block SHALL provide port busy, output, 1 bit: byte transfer in progress.
REQ-014 The block SHALL provide port underrun, output, 1 bit: sticky transmit-underrun flag.

Function
REQ-015 Sclk, SS and MOSI SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized Sclk.
REQ-016 Supported Sclk half-period SHALL be at least 4 clk cycles, i.e. master clkdiv of 01 or above on a shared clk.
REQ-017 MODE SHALL be latched on the synchronized SS falling edge and held for the whole select period.
REQ-018 Leading edge = Sclk leaving CPOL; trailing edge = return to CPOL.
REQ-019 CPHA=0: sample MOSI on the leading edge, shift MISO on the trailing edge; the MSB SHALL be on MISO from the SS falling edge.
REQ-020 CPHA=1: shift on the leading edge (first leading edge presents the MSB), sample on the trailing edge.
REQ-021 Data order SHALL be MSB first, both directions, 8 bits per byte.
REQ-022 States SHALL be IDLE, XFER, DONE. IDLE->XFER on synced SS fall; XFER->DONE on 8th sample; DONE->XFER if SS still low (back-to-back byte); DONE->IDLE if SS high.
REQ-023 On entry to XFER the tx shift register SHALL load the tx buffer, or 8'h00 if the buffer is empty; bit counter SHALL clear to 0.
REQ-024 In DONE, rx_data SHALL take the 8 sampled bits and rx_valid SHALL be 1 for exactly that cycle (2 clk after sample-edge detection).
REQ-025 tx_load while tx_ready=1 SHALL capture tx_data and clear tx_ready next cycle; tx_load while tx_ready=0 SHALL be ignored.
REQ-026 The buffer SHALL be consumed on XFER entry; tx_ready SHALL return to 1 the following cycle.
REQ-027 busy SHALL be 1 in XFER and DONE, 0 in IDLE.
REQ-028 SS rising in XFER SHALL return the block to IDLE next cycle; the partial byte is discarded, with no rx_valid.
REQ-029 Simultaneous tx_load and buffer consumption: the consumption SHALL take the old content and the new byte SHALL be captured.
REQ-030 MISO SHALL be combinational: SS raw high -> Z, else shift-register bit 7.

Reset
REQ-031 With rst=0 at a clk edge, the block SHALL go to IDLE with rx_data=0, rx_valid=0, tx_ready=1, busy=0, underrun=0, shift registers=0 and bit counter=0.
REQ-032 During reset, the synchronizer flops SHALL preset to SS=1 and Sclk=CPOL of the current MODE, so that no spurious edge occurs after release.
REQ-033 Reset mid-transfer SHALL abort the transfer; no rx_valid SHALL follow.

Configuration
REQ-034 With SPI_SLAVE_UNDERRUN_EN defined, underrun SHALL set on XFER entry with the buffer empty and clear on rst or an accepted tx_load.
REQ-035 Without SPI_SLAVE_UNDERRUN_EN, underrun SHALL be tied to 0 and its logic SHALL be absent.

Structure
REQ-036 Package spi_pkg SHALL hold the state enum (IDLE/XFER/DONE), the MODE encodings, and the constant SPI_BITS=8.
REQ-037 One sub-module, spi_sync (2-flop synchronizer with reset preset value), SHALL be instantiated for each of Sclk, SS and MOSI.

Verification
REQ-038 Mode 0, Sclk=clk/8, tx_load 8'hA5, master sends 8'h3C -> MISO bits 10100101, rx_data=8'h3C, one rx_valid pulse.
REQ-039 Modes 1, 2, 3, each with tx 8'h81 and rx 8'h7E -> correct bytes in both directions, no extra rx_valid.
REQ-040 Two bytes under one SS low, second tx_load during byte 1 -> two rx_valid pulses; second MISO byte equals the second load.
REQ-041 SS high after 4 Sclk periods -> IDLE, busy=0, no rx_valid, rx_data unchanged.
REQ-042 Byte started with no tx_load -> MISO all 0 and underrun=1 (macro on), underrun=0 (macro off); a later tx_load clears it.
REQ-043 rst=0 mid-byte, then a fresh full byte 8'hC3 -> all outputs at reset values, then rx_data=8'hC3 received normally.
